// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default framing constants.
package uart_pkg;

  localparam int unsigned ClksPerBitDefault = 16;
  localparam int unsigned DataBitsDefault   = 8;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StParity   = 3'd3,
    StStop     = 3'd4,
    StWaitIdle = 3'd5
  } uart_state_e;

endpackage

// File: rtl/synchronizer.sv
// Multi-stage flop synchronizer for asynchronous inputs; deliberately has no reset.
module synchronizer #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk_i) begin
    sync_q[0] <= d_i;
    for (int i = 1; i < STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, LSB first, 1 stop bit. Define UART_RX_PARITY_EN to expect one
// even-parity bit after the data bits; otherwise parity_error is tied low.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = ClksPerBitDefault,
  parameter int unsigned DATA_BITS    = DataBitsDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
`ifdef UART_RX_PARITY_EN
  // Running XOR over data and parity bits; nonzero at STOP means odd total.
  logic                 par_q, par_d;
`endif

  synchronizer #(
    .STAGES(2),
    .WIDTH (1)
  ) u_rx_sync (
    .clk_i(clk),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    fe_d    = 1'b0;
    pe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          idx_d   = '0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          // A line that is high again at mid-start-bit was only a glitch.
          state_d = rx_s ? StIdle : StData;
`ifdef UART_RX_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end

      StData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + IdxW'(1);
`ifdef UART_RX_PARITY_EN
          par_d   = par_q ^ rx_s;
          if (idx_q == IdxLast) state_d = StParity;
`else
          if (idx_q == IdxLast) state_d = StStop;
`endif
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          par_d   = par_q ^ rx_s;
          state_d = StStop;
        end
      end
`endif

      StStop: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_q) begin
              pe_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            fe_d    = 1'b1;
            state_d = StWaitIdle;
          end
        end
      end

      StWaitIdle: begin
        cnt_d = '0;
        if (rx_s) state_d = StIdle;
      end

      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign frame_error  = fe_q;
  assign parity_error = pe_q;
  assign busy         = (state_q != StIdle);

endmodule
